// File: rtl/collision_damage_unit.sv
// collision_damage_unit
//   Detects overlap between the player ship and hostile objects streamed one
//   per cycle by the object scan logic, issues at most one single-cycle damage
//   pulse per scan frame, then holds a frame-counted invulnerability window.
//
// Ports
//   clk           system clock
//   resetn        asynchronous active-low reset
//   startGameEn   game start/restart (highest priority, returns to ARMED)
//   ship_x/ship_y ship bounding-box top-left, stable during a scan
//   ship_health   current health from the downstream health stage
//   obj_valid     obj_x/obj_y hold a live hostile object this cycle
//   obj_x/obj_y   object bounding-box top-left
//   obj_last      qualified by obj_valid; final object of the scan
//   frame_tick    one-cycle pulse per video frame
//   health_update single-cycle damage pulse to the health stage
//   invuln        high during the invulnerability window
//   ship_blink    invuln AND bit 2 of the remaining-frame counter
module collision_damage_unit #(
  parameter int unsigned X_W           = 8,
  parameter int unsigned Y_W           = 7,
  parameter int unsigned SHIP_W        = 8,
  parameter int unsigned SHIP_H        = 8,
  parameter int unsigned OBJ_W         = 4,
  parameter int unsigned OBJ_H         = 4,
  parameter int unsigned INVULN_FRAMES = 60
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           startGameEn,
  input  logic [X_W-1:0] ship_x,
  input  logic [Y_W-1:0] ship_y,
  input  logic [3:0]     ship_health,
  input  logic           obj_valid,
  input  logic [X_W-1:0] obj_x,
  input  logic [Y_W-1:0] obj_y,
  input  logic           obj_last,
  input  logic           frame_tick,
  output logic           health_update,
  output logic           invuln,
  output logic           ship_blink
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_HIT,
    S_INVULN
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_latch;
  logic       w_latch_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  // Box edges are widened by one bit so right/bottom edges near the top of
  // the coordinate range never wrap back to small values.
  logic [X_W:0] w_ship_x0;
  logic [X_W:0] w_ship_x1;
  logic [X_W:0] w_obj_x0;
  logic [X_W:0] w_obj_x1;
  logic [Y_W:0] w_ship_y0;
  logic [Y_W:0] w_ship_y1;
  logic [Y_W:0] w_obj_y0;
  logic [Y_W:0] w_obj_y1;
  logic         w_hit_now;
  logic         w_dead;

  assign w_ship_x0 = {1'b0, ship_x};
  assign w_ship_x1 = w_ship_x0 + (X_W+1)'(SHIP_W);
  assign w_obj_x0  = {1'b0, obj_x};
  assign w_obj_x1  = w_obj_x0 + (X_W+1)'(OBJ_W);
  assign w_ship_y0 = {1'b0, ship_y};
  assign w_ship_y1 = w_ship_y0 + (Y_W+1)'(SHIP_H);
  assign w_obj_y0  = {1'b0, obj_y};
  assign w_obj_y1  = w_obj_y0 + (Y_W+1)'(OBJ_H);

  // Strict compares: boxes that only touch along an edge do not collide.
  assign w_hit_now = (w_obj_x0 < w_ship_x1) && (w_ship_x0 < w_obj_x1) &&
                     (w_obj_y0 < w_ship_y1) && (w_ship_y0 < w_obj_y1);

  assign w_dead = (ship_health == 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_latch <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_latch <= w_latch_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_latch_nxt   = r_latch;
    w_cnt_nxt     = r_cnt;
    health_update = 1'b0;

    if (startGameEn) begin
      w_state_nxt = S_ARMED;
      w_latch_nxt = 1'b0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_latch_nxt = 1'b0;
        end

        S_ARMED: begin
          if (w_dead) begin
            w_state_nxt = S_IDLE;
            w_latch_nxt = 1'b0;
          end else if (obj_valid) begin
            if (obj_last) begin
              // The last object's own overlap counts for this scan, so it
              // is OR-ed in rather than waiting for the latch to update.
              w_latch_nxt = 1'b0;
              if (r_latch || w_hit_now) begin
                w_state_nxt = S_HIT;
              end
            end else if (w_hit_now) begin
              w_latch_nxt = 1'b1;
            end
          end
        end

        S_HIT: begin
          w_latch_nxt = 1'b0;
          if (w_dead) begin
            w_state_nxt = S_IDLE;
          end else begin
            health_update = 1'b1;
            w_cnt_nxt     = 8'(INVULN_FRAMES);
            w_state_nxt   = S_INVULN;
          end
        end

        S_INVULN: begin
          w_latch_nxt = 1'b0;
          if (w_dead) begin
            w_state_nxt = S_IDLE;
          end else if (frame_tick) begin
            if (r_cnt <= 8'd1) begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_ARMED;
            end else begin
              w_cnt_nxt = r_cnt - 8'd1;
            end
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_latch_nxt = 1'b0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Decoded straight from the state register so an asynchronous reset drops
  // them immediately.
  always_comb begin
    invuln     = (r_state == S_INVULN);
    ship_blink = (r_state == S_INVULN) && r_cnt[2];
  end

endmodule

// File: tb/tb_collision_damage_unit.sv
module tb_collision_damage_unit;

  logic       clk;
  logic       resetn;
  logic       startGameEn;
  logic [7:0] ship_x;
  logic [6:0] ship_y;
  logic [3:0] ship_health;
  logic       obj_valid;
  logic [7:0] obj_x;
  logic [6:0] obj_y;
  logic       obj_last;
  logic       frame_tick;
  logic       health_update;
  logic       invuln;
  logic       ship_blink;

  int checks = 0;
  int errors = 0;

  collision_damage_unit #(
    .X_W          (8),
    .Y_W          (7),
    .SHIP_W       (8),
    .SHIP_H       (8),
    .OBJ_W        (4),
    .OBJ_H        (4),
    .INVULN_FRAMES(6)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .startGameEn  (startGameEn),
    .ship_x       (ship_x),
    .ship_y       (ship_y),
    .ship_health  (ship_health),
    .obj_valid    (obj_valid),
    .obj_x        (obj_x),
    .obj_y        (obj_y),
    .obj_last     (obj_last),
    .frame_tick   (frame_tick),
    .health_update(health_update),
    .invuln       (invuln),
    .ship_blink   (ship_blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus drivers: each occupies exactly one clock and returns #1 after
  // the edge that sampled it.
  task automatic beat(input logic v, input logic [7:0] x, input logic [6:0] y,
                      input logic last);
    obj_valid = v;
    obj_x     = x;
    obj_y     = y;
    obj_last  = last;
    @(posedge clk); #1;
    obj_valid = 1'b0;
    obj_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic start();
    startGameEn = 1'b1;
    @(posedge clk); #1;
    startGameEn = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL reset_hu: got %0b expected 0", health_update); end
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL reset_invuln: got %0b expected 0", invuln); end
    checks++; if (ship_blink !== 1'b0) begin errors++; $display("FAIL reset_blink: got %0b expected 0", ship_blink); end
    resetn = 1'b1;
    // IDLE ignores overlapping objects.
    beat(1'b1, 8'd44, 7'd104, 1'b1);
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL idle_ignore_hu: got %0b expected 0", health_update); end
    idle_cycle();
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL idle_ignore_invuln: got %0b expected 0", invuln); end
  endtask

  task automatic test_no_hit();
    start();
    beat(1'b1, 8'd10, 7'd10, 1'b0);
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL nohit_mid_hu: got %0b expected 0", health_update); end
    beat(1'b1, 8'd80, 7'd50, 1'b1);
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL nohit_last_hu: got %0b expected 0", health_update); end
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL nohit_invuln: got %0b expected 0", invuln); end
    idle_cycle();
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL nohit_after_hu: got %0b expected 0", health_update); end
  endtask

  task automatic test_hit();
    beat(1'b1, 8'd44, 7'd104, 1'b0);
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL hit_mid_hu: got %0b expected 0", health_update); end
    beat(1'b1, 8'd0, 7'd0, 1'b1);
    checks++; if (health_update !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %0b expected 1", health_update); end
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL hit_cycle_invuln: got %0b expected 0", invuln); end
    idle_cycle();
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL hit_single_pulse: got %0b expected 0", health_update); end
    checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL hit_invuln: got %0b expected 1", invuln); end
    // counter = 6 (3'b110): bit 2 set
    checks++; if (ship_blink !== 1'b1) begin errors++; $display("FAIL hit_blink: got %0b expected 1", ship_blink); end
  endtask

  task automatic test_invuln_window();
    // Expected after tick k: counter 6-k; blink = bit 2, invuln until k=6.
    logic exp_blink [1:6];
    logic exp_inv   [1:6];
    exp_blink[1] = 1'b1; exp_inv[1] = 1'b1;
    exp_blink[2] = 1'b1; exp_inv[2] = 1'b1;
    exp_blink[3] = 1'b0; exp_inv[3] = 1'b1;
    exp_blink[4] = 1'b0; exp_inv[4] = 1'b1;
    exp_blink[5] = 1'b0; exp_inv[5] = 1'b1;
    exp_blink[6] = 1'b0; exp_inv[6] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      beat(1'b1, 8'd44, 7'd104, 1'b1);
      checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL window_hu k=%0d: got %0b expected 0", k, health_update); end
      tick();
      checks++; if (invuln !== exp_inv[k]) begin errors++; $display("FAIL window_invuln k=%0d: got %0b expected %0b", k, invuln, exp_inv[k]); end
      checks++; if (ship_blink !== exp_blink[k]) begin errors++; $display("FAIL window_blink k=%0d: got %0b expected %0b", k, ship_blink, exp_blink[k]); end
    end
    beat(1'b1, 8'd44, 7'd104, 1'b1);
    checks++; if (health_update !== 1'b1) begin errors++; $display("FAIL window_second_pulse: got %0b expected 1", health_update); end
    start();
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL window_restart_invuln: got %0b expected 0", invuln); end
  endtask

  task automatic test_edges();
    logic [7:0] tx [0:8];
    logic [6:0] ty [0:8];
    logic       te [0:8];
    tx[0] = 8'd48; ty[0] = 7'd100; te[0] = 1'b0;
    tx[1] = 8'd47; ty[1] = 7'd100; te[1] = 1'b1;
    tx[2] = 8'd36; ty[2] = 7'd100; te[2] = 1'b0;
    tx[3] = 8'd37; ty[3] = 7'd100; te[3] = 1'b1;
    tx[4] = 8'd40; ty[4] = 7'd108; te[4] = 1'b0;
    tx[5] = 8'd40; ty[5] = 7'd107; te[5] = 1'b1;
    tx[6] = 8'd40; ty[6] = 7'd96;  te[6] = 1'b0;
    tx[7] = 8'd40; ty[7] = 7'd97;  te[7] = 1'b1;
    tx[8] = 8'd30; ty[8] = 7'd90;  te[8] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      beat(1'b1, tx[i], ty[i], 1'b1);
      checks++; if (health_update !== te[i]) begin errors++; $display("FAIL edge(%0d,%0d): got %0b expected %0b", tx[i], ty[i], health_update, te[i]); end
      if (te[i]) start();
    end
    // Ship near top of range: 250+8 and 125+8 need the extra bit.
    ship_x = 8'd250; ship_y = 7'd125;
    beat(1'b1, 8'd254, 7'd126, 1'b1);
    checks++; if (health_update !== 1'b1) begin errors++; $display("FAIL edge_nowrap: got %0b expected 1", health_update); end
    start();
    ship_x = 8'd40; ship_y = 7'd100;
  endtask

  task automatic test_back_to_back();
    beat(1'b1, 8'd10, 7'd10, 1'b1);
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL b2b_scan1: got %0b expected 0", health_update); end
    beat(1'b1, 8'd44, 7'd104, 1'b0);
    beat(1'b0, 8'd44, 7'd104, 1'b1);
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL b2b_invalid_last: got %0b expected 0", health_update); end
    beat(1'b1, 8'd0, 7'd0, 1'b1);
    checks++; if (health_update !== 1'b1) begin errors++; $display("FAIL b2b_latched_pulse: got %0b expected 1", health_update); end
    idle_cycle();
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL b2b_single: got %0b expected 0", health_update); end
    checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL b2b_invuln: got %0b expected 1", invuln); end
    start();
  endtask

  task automatic test_death();
    ship_health = 4'd0;
    beat(1'b1, 8'd44, 7'd104, 1'b1);
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL death_armed_hu: got %0b expected 0", health_update); end
    idle_cycle();
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL death_armed_hu2: got %0b expected 0", health_update); end
    ship_health = 4'd5;
    beat(1'b1, 8'd44, 7'd104, 1'b1);
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL death_idle_hu: got %0b expected 0", health_update); end
    start();
    beat(1'b1, 8'd44, 7'd104, 1'b1);
    checks++; if (health_update !== 1'b1) begin errors++; $display("FAIL death_restart_pulse: got %0b expected 1", health_update); end
    idle_cycle();
    ship_health = 4'd0;
    idle_cycle();
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL death_invuln_exit: got %0b expected 0", invuln); end
    ship_health = 4'd5;
    start();
    beat(1'b1, 8'd44, 7'd104, 1'b1);
    ship_health = 4'd0;
    #1;
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL death_hit_entry: got %0b expected 0", health_update); end
    @(posedge clk); #1;
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL death_hit_idle: got %0b expected 0", invuln); end
    ship_health = 4'd5;
    start();
  endtask

  task automatic test_start_priority();
    startGameEn = 1'b1;
    beat(1'b1, 8'd44, 7'd104, 1'b1);
    startGameEn = 1'b0;
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL start_last_hu: got %0b expected 0", health_update); end
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL start_last_invuln: got %0b expected 0", invuln); end
    beat(1'b1, 8'd44, 7'd104, 1'b1);
    checks++; if (health_update !== 1'b1) begin errors++; $display("FAIL start_armed_pulse: got %0b expected 1", health_update); end
    startGameEn = 1'b1;
    #1;
    checks++; if (health_update !== 1'b0) begin errors++; $display("FAIL start_kills_pulse: got %0b expected 0", health_update); end
    @(posedge clk); #1;
    startGameEn = 1'b0;
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL start_hit_invuln: got %0b expected 0", invuln); end
  endtask

  task automatic test_reset_mid();
    beat(1'b1, 8'd44, 7'd104, 1'b1);
    idle_cycle();
    checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL rstmid_pre_invuln: got %0b expected 1", invuln); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL rstmid_async_invuln: got %0b expected 0", invuln); end
    checks++; if (ship_blink !== 1'b0) begin errors++; $display("FAIL rstmid_async_blink: got %0b expected 0", ship_blink); end
    @(posedge clk); #1;
    resetn = 1'b1;
    start();
    beat(1'b1, 8'd44, 7'd104, 1'b1);
    checks++; if (health_update !== 1'b1) begin errors++; $display("FAIL rstmid_rearm_pulse: got %0b expected 1", health_update); end
  endtask

  initial begin
    resetn      = 1'b0;
    startGameEn = 1'b0;
    ship_x      = 8'd40;
    ship_y      = 7'd100;
    ship_health = 4'd5;
    obj_valid   = 1'b0;
    obj_x       = '0;
    obj_y       = '0;
    obj_last    = 1'b0;
    frame_tick  = 1'b0;

    test_reset();
    test_no_hit();
    test_hit();
    test_invuln_window();
    test_edges();
    test_back_to_back();
    test_death();
    test_start_priority();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
